// File: rtl/a2d_arbiter_if.sv
// Bundle of requester-side and A2D-side signals around the arbiter.
// master = surrounding environment, slave = the arbiter itself.
interface a2d_arbiter_if;
    logic [2:0]  req;
    logic [2:0]  chnl0;
    logic [2:0]  chnl1;
    logic [2:0]  chnl2;
    logic [2:0]  done;
    logic [2:0]  err;
    logic [11:0] rd_data;
    logic        busy;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] res;

    modport master (
        output req, chnl0, chnl1, chnl2, cnv_cmplt, res,
        input  done, err, rd_data, busy, strt_cnv, chnnl
    );

    modport slave (
        input  req, chnl0, chnl1, chnl2, cnv_cmplt, res,
        output done, err, rd_data, busy, strt_cnv, chnnl
    );
endinterface

// File: rtl/a2d_arbiter.sv
// Round-robin arbiter sharing one A2D converter between three requesters,
// with a per-conversion timeout. Every output is a flop.
module a2d_arbiter #(
    parameter int TIMEOUT = 4096
) (
    input  logic          clk,
    input  logic          rst,
    a2d_arbiter_if.slave  bus
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [1:0]    last_gnt_q, last_gnt_d;
    logic [1:0]    id_q, id_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    chnnl_q, chnnl_d;
    logic          strt_q, strt_d;
    logic [2:0]    done_q, done_d;
    logic [2:0]    err_q, err_d;
    logic [11:0]   rd_q, rd_d;
    logic          busy_q, busy_d;

    logic [1:0] c1, c2, win;
    logic [2:0] win_chnl;

    function automatic logic [1:0] rr_next(input logic [1:0] g);
        case (g)
            2'd0:    rr_next = 2'd1;
            2'd1:    rr_next = 2'd2;
            default: rr_next = 2'd0;
        endcase
    endfunction

    // Candidates in priority order after the last grant; last_gnt itself is the fallback.
    always_comb begin
        c1 = rr_next(last_gnt_q);
        c2 = rr_next(c1);
        if (bus.req[c1])      win = c1;
        else if (bus.req[c2]) win = c2;
        else                  win = last_gnt_q;
        case (win)
            2'd0:    win_chnl = bus.chnl0;
            2'd1:    win_chnl = bus.chnl1;
            default: win_chnl = bus.chnl2;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        id_d       = id_q;
        cnt_d      = cnt_q;
        chnnl_d    = chnnl_q;
        rd_d       = rd_q;
        strt_d     = 1'b0;
        done_d     = 3'b000;
        err_d      = 3'b000;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    id_d       = win;
                    last_gnt_d = win;
                    chnnl_d    = win_chnl;
                    strt_d     = 1'b1;
                    state_d    = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // Completion wins over a timeout landing in the same cycle.
                if (bus.cnv_cmplt) begin
                    rd_d    = bus.res;
                    done_d  = 3'b001 << id_q;
                    state_d = DONE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    done_d  = 3'b001 << id_q;
                    err_d   = 3'b001 << id_q;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_gnt_q <= 2'd2;
            id_q       <= 2'd0;
            cnt_q      <= '0;
            chnnl_q    <= 3'b000;
            strt_q     <= 1'b0;
            done_q     <= 3'b000;
            err_q      <= 3'b000;
            rd_q       <= 12'h000;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            id_q       <= id_d;
            cnt_q      <= cnt_d;
            chnnl_q    <= chnnl_d;
            strt_q     <= strt_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rd_q       <= rd_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.strt_cnv = strt_q;
    assign bus.chnnl    = chnnl_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.rd_data  = rd_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_a2d_arbiter.sv
// Directed bench for a2d_arbiter: a per-cycle vector table for reset, a single
// request and round-robin contention, then hand sequences for timing corners.
module tb_a2d_arbiter;
    logic clk;
    logic rst;
    a2d_arbiter_if bus ();

    a2d_arbiter #(.TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [2:0]  req;
        logic        cnv;
        logic [11:0] res;
        logic [22:0] exp;
    } vec_t;

    vec_t vq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // {busy, strt_cnv, done, err, chnnl, rd_data}
    function automatic logic [22:0] ex(input logic b, input logic s, input logic [2:0] d,
                                       input logic [2:0] e, input logic [2:0] c, input logic [11:0] r);
        ex = {b, s, d, e, c, r};
    endfunction

    function automatic vec_t mk(input logic r, input logic [2:0] q, input logic cv,
                                input logic [11:0] rs, input logic [22:0] e);
        vec_t v;
        v.rst = r; v.req = q; v.cnv = cv; v.res = rs; v.exp = e;
        return v;
    endfunction

    function automatic logic [22:0] obs();
        obs = {bus.busy, bus.strt_cnv, bus.done, bus.err, bus.chnnl, bus.rd_data};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.req = 3'b000;
        bus.cnv_cmplt = 1'b0;
        bus.res = 12'h000;
        bus.chnl0 = 3'd3;
        bus.chnl1 = 3'd5;
        bus.chnl2 = 3'd6;

        // Reset, including with requests pending.
        vq.push_back(mk(1, 3'b000, 0, 12'h000, ex(0, 0, 3'b000, 3'b000, 3'd0, 12'h000)));
        vq.push_back(mk(1, 3'b111, 0, 12'h000, ex(0, 0, 3'b000, 3'b000, 3'd0, 12'h000)));
        // Single request on requester 0, completion 10 cycles after strt_cnv.
        vq.push_back(mk(0, 3'b001, 0, 12'h000, ex(1, 1, 3'b000, 3'b000, 3'd3, 12'h000)));
        for (int i = 0; i < 10; i++)
            vq.push_back(mk(0, 3'b001, 0, 12'hFFF, ex(1, 0, 3'b000, 3'b000, 3'd3, 12'h000)));
        vq.push_back(mk(0, 3'b001, 1, 12'hA5C, ex(1, 0, 3'b001, 3'b000, 3'd3, 12'hA5C)));
        vq.push_back(mk(0, 3'b000, 0, 12'h000, ex(0, 0, 3'b000, 3'b000, 3'd3, 12'hA5C)));
        // cnv_cmplt in IDLE must not touch rd_data.
        vq.push_back(mk(0, 3'b000, 1, 12'h123, ex(0, 0, 3'b000, 3'b000, 3'd3, 12'hA5C)));
        // Contention with all three requests held after a fresh reset.
        vq.push_back(mk(1, 3'b000, 0, 12'h000, ex(0, 0, 3'b000, 3'b000, 3'd0, 12'h000)));
        vq.push_back(mk(0, 3'b111, 0, 12'h000, ex(1, 1, 3'b000, 3'b000, 3'd3, 12'h000)));
        vq.push_back(mk(0, 3'b111, 0, 12'h000, ex(1, 0, 3'b000, 3'b000, 3'd3, 12'h000)));
        vq.push_back(mk(0, 3'b111, 1, 12'h111, ex(1, 0, 3'b001, 3'b000, 3'd3, 12'h111)));
        vq.push_back(mk(0, 3'b111, 0, 12'h000, ex(0, 0, 3'b000, 3'b000, 3'd3, 12'h111)));
        vq.push_back(mk(0, 3'b111, 0, 12'h000, ex(1, 1, 3'b000, 3'b000, 3'd5, 12'h111)));
        vq.push_back(mk(0, 3'b111, 0, 12'h000, ex(1, 0, 3'b000, 3'b000, 3'd5, 12'h111)));
        vq.push_back(mk(0, 3'b111, 1, 12'h222, ex(1, 0, 3'b010, 3'b000, 3'd5, 12'h222)));
        vq.push_back(mk(0, 3'b111, 0, 12'h000, ex(0, 0, 3'b000, 3'b000, 3'd5, 12'h222)));
        vq.push_back(mk(0, 3'b111, 0, 12'h000, ex(1, 1, 3'b000, 3'b000, 3'd6, 12'h222)));
        vq.push_back(mk(0, 3'b111, 0, 12'h000, ex(1, 0, 3'b000, 3'b000, 3'd6, 12'h222)));
        vq.push_back(mk(0, 3'b111, 1, 12'h333, ex(1, 0, 3'b100, 3'b000, 3'd6, 12'h333)));
        vq.push_back(mk(0, 3'b111, 0, 12'h000, ex(0, 0, 3'b000, 3'b000, 3'd6, 12'h333)));
        vq.push_back(mk(0, 3'b111, 0, 12'h000, ex(1, 1, 3'b000, 3'b000, 3'd3, 12'h333)));
        vq.push_back(mk(1, 3'b000, 0, 12'h000, ex(0, 0, 3'b000, 3'b000, 3'd0, 12'h000)));

        foreach (vq[i]) begin
            rst = vq[i].rst;
            bus.req = vq[i].req;
            bus.cnv_cmplt = vq[i].cnv;
            bus.res = vq[i].res;
            step();
            chk($sformatf("vec%0d", i), 32'(obs()), 32'(vq[i].exp));
        end
        rst = 1'b0;
        bus.req = 3'b000;
        bus.cnv_cmplt = 1'b0;

        // Timeout on requester 1: done and err together 17 cycles after strt_cnv.
        bus.req = 3'b010;
        bus.res = 12'hFFF;
        step();
        chk("to_start", {bus.strt_cnv, bus.chnnl}, {1'b1, 3'd5});
        for (int k = 1; k <= 17; k++) begin
            step();
            if (k < 17)
                chk($sformatf("to_wait%0d", k), {bus.busy, bus.strt_cnv, bus.done}, {1'b1, 1'b0, 3'b000});
            else
                chk("to_done", {bus.done, bus.err, bus.rd_data}, {3'b010, 3'b010, 12'h000});
        end
        bus.req = 3'b000;
        step();
        chk("to_idle", {bus.busy, bus.done, bus.err}, {1'b0, 3'b000, 3'b000});

        // Late request from requester 2 while requester 0 converts.
        bus.req = 3'b001;
        step();
        chk("late_start0", {bus.strt_cnv, bus.chnnl}, {1'b1, 3'd3});
        step();
        bus.req = 3'b101;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("late_wait%0d", k), {bus.busy, bus.strt_cnv, bus.chnnl}, {1'b1, 1'b0, 3'd3});
        end
        bus.cnv_cmplt = 1'b1;
        bus.res = 12'h0F0;
        step();
        chk("late_done0", {bus.strt_cnv, bus.done, bus.rd_data}, {1'b0, 3'b001, 12'h0F0});
        bus.cnv_cmplt = 1'b0;
        bus.req = 3'b100;
        step();
        chk("late_idle", {bus.busy, bus.strt_cnv}, {1'b0, 1'b0});
        step();
        chk("late_start2", {bus.strt_cnv, bus.chnnl}, {1'b1, 3'd6});
        step();
        bus.cnv_cmplt = 1'b1;
        bus.res = 12'h5A5;
        step();
        chk("late_done2", {bus.done, bus.err, bus.rd_data}, {3'b100, 3'b000, 12'h5A5});
        bus.cnv_cmplt = 1'b0;
        bus.req = 3'b000;
        step();

        // Reset mid-WAIT abandons the conversion and restores last_gnt.
        bus.req = 3'b001;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        chk("rst_wait", 32'(obs()), 32'(ex(0, 0, 3'b000, 3'b000, 3'd0, 12'h000)));
        rst = 1'b0;
        bus.req = 3'b000;
        bus.cnv_cmplt = 1'b1;
        bus.res = 12'h777;
        step();
        chk("rst_cmplt_ign", {bus.busy, bus.done, bus.rd_data}, {1'b0, 3'b000, 12'h000});
        bus.cnv_cmplt = 1'b0;
        step();
        chk("rst_no_done", {bus.busy, bus.done}, {1'b0, 3'b000});
        bus.req = 3'b111;
        step();
        chk("rst_gnt0", {bus.strt_cnv, bus.chnnl}, {1'b1, 3'd3});
        rst = 1'b1;
        bus.req = 3'b000;
        step();
        rst = 1'b0;

        // cnv_cmplt on the final timeout cycle counts as success.
        bus.req = 3'b100;
        step();
        chk("co_start", {bus.strt_cnv, bus.chnnl}, {1'b1, 3'd6});
        for (int k = 1; k <= 16; k++) begin
            step();
            chk($sformatf("co_wait%0d", k), {bus.busy, bus.done}, {1'b1, 3'b000});
        end
        bus.cnv_cmplt = 1'b1;
        bus.res = 12'hABC;
        step();
        chk("co_done", {bus.done, bus.err, bus.rd_data}, {3'b100, 3'b000, 12'hABC});
        bus.cnv_cmplt = 1'b0;
        bus.req = 3'b000;
        step();
        chk("co_idle", {bus.busy, bus.done, bus.err}, {1'b0, 3'b000, 3'b000});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
